// File: rtl/lcd_pkg.sv
// Shared types and constants for the 8080-bus LCD init/fill writer.
// ROM word layout: [17:16] opcode, [15:0] value.
package lcd_pkg;

  localparam int unsigned WORD_W      = 18;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned PIXEL_COUNT = 76800;  // 320 x 240

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROM,
    DECODE,
    WR_LO,
    WR_HI,
    DELAY,
    ADVANCE,
    DONE
  } state_t;

  function automatic logic is_bus_write(input opcode_t op);
    return (op == OP_CMD) || (op == OP_DATA);
  endfunction

endpackage

// File: rtl/lcd_init_writer_if.sv
// 8080-style parallel LCD write bus: chip select, data/command, write strobe, data.
interface lcd_init_writer_if;
  import lcd_pkg::*;

  logic              lcd_cs_n;
  logic              lcd_dc;
  logic              lcd_wr_n;
  logic [DATA_W-1:0] lcd_data;

  modport master (output lcd_cs_n, output lcd_dc, output lcd_wr_n, output lcd_data);
  modport slave  (input  lcd_cs_n, input  lcd_dc, input  lcd_wr_n, input  lcd_data);

endinterface

// File: rtl/lcd_delay_timer.sv
// Down-counter for DELAY words; expired is high on the last cycle of a loaded delay.
module lcd_delay_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        count,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] remain;

  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= '0;
    end else if (load) begin
      remain <= load_val;
    end else if (count && (remain != '0)) begin
      remain <= remain - 32'd1;
    end
  end

  // Loaded with N, the Nth counting cycle sees remain==1.
  always_comb begin
    expired = (remain <= 32'd1);
  end

endmodule

// File: rtl/lcd_init_writer.sv
// Walks an upstream ROM of CMD/DATA/DELAY/END words and replays them as 8080 bus writes.
// All outputs are registered from the next state so wr_n and cs_n never glitch.
module lcd_init_writer
  import lcd_pkg::*;
#(
  parameter int unsigned WR_LO_CYC  = 2,
  parameter int unsigned WR_HI_CYC  = 2,
  parameter int unsigned CLK_PER_MS = 50000,
  parameter int unsigned ROM_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] rom_word,
  output logic              cnt_en,
  output logic              busy,
  output logic              done,
  lcd_init_writer_if.master lcd
);

  state_t            state, next_state;
  logic [31:0]       phase_cnt;
  opcode_t           word_op;
  logic [DATA_W-1:0] word_val;
  logic              dly_load, dly_count, dly_expired;
  logic [31:0]       dly_len;

  logic              cnt_en_d, busy_d, done_d;
  logic              cs_n_q, cs_n_d;
  logic              wr_n_q, wr_n_d;
  logic              dc_q, dc_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    word_op  = opcode_t'(rom_word[WORD_W-1:DATA_W]);
    word_val = rom_word[DATA_W-1:0];
  end

  always_comb begin
    dly_load  = (state == DECODE) && (word_op == OP_DELAY);
    dly_count = (state == DELAY);
    dly_len   = 32'(word_val) * CLK_PER_MS;
  end

  lcd_delay_timer u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .count    (dly_count),
    .load_val (dly_len),
    .expired  (dly_expired)
  );

  // State register; the phase counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      cnt_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      dc_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state     <= next_state;
      phase_cnt <= (next_state != state) ? '0 : phase_cnt + 32'd1;
      cnt_en    <= cnt_en_d;
      busy      <= busy_d;
      done      <= done_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      dc_q      <= dc_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = WAIT_ROM;
      WAIT_ROM: if (phase_cnt == ROM_LAT - 1) next_state = DECODE;
      DECODE: begin
        case (word_op)
          OP_CMD, OP_DATA: next_state = WR_LO;
          OP_DELAY:        next_state = (word_val == '0) ? ADVANCE : DELAY;
          OP_END:          next_state = DONE;
          default:         next_state = DONE;
        endcase
      end
      WR_LO:    if (phase_cnt == WR_LO_CYC - 1) next_state = WR_HI;
      WR_HI:    if (phase_cnt == WR_HI_CYC - 1) next_state = ADVANCE;
      DELAY:    if (dly_expired) next_state = ADVANCE;
      ADVANCE:  next_state = WAIT_ROM;
      DONE:     next_state = DONE;
      default:  next_state = IDLE;
    endcase
  end

  // Output values for the coming cycle; data/dc are loaded only when a write is decoded.
  always_comb begin
    cnt_en_d = (next_state == ADVANCE);
    busy_d   = (next_state != IDLE) && (next_state != DONE);
    done_d   = (next_state == DONE);
    wr_n_d   = (next_state != WR_LO);
    cs_n_d   = cs_n_q;
    dc_d     = dc_q;
    data_d   = data_q;
    if ((state == DECODE) && is_bus_write(word_op)) begin
      cs_n_d = 1'b0;
      dc_d   = rom_word[DATA_W];
      data_d = word_val;
    end
    if (next_state == DONE) begin
      cs_n_d = 1'b1;
    end
  end

  assign lcd.lcd_cs_n = cs_n_q;
  assign lcd.lcd_wr_n = wr_n_q;
  assign lcd.lcd_dc   = dc_q;
  assign lcd.lcd_data = data_q;

endmodule

// File: tb/tb_lcd_init_writer.sv
// Random ROM programs replayed through lcd_init_writer, checked against a word-level timing model.
module tb_lcd_init_writer;
  import lcd_pkg::*;

  localparam int unsigned LO  = 2;
  localparam int unsigned HI  = 2;
  localparam int unsigned CPM = 10;
  localparam int unsigned LAT = 2;
  localparam logic [1:0]  C_CMD = 2'b00, C_DATA = 2'b01, C_DLY = 2'b10, C_END = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] rom_word = '0;
  logic        cnt_en, busy, done;

  lcd_init_writer_if lcd ();

  lcd_init_writer #(
    .WR_LO_CYC  (LO),
    .WR_HI_CYC  (HI),
    .CLK_PER_MS (CPM),
    .ROM_LAT    (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_word (rom_word),
    .cnt_en   (cnt_en),
    .busy     (busy),
    .done     (done),
    .lcd      (lcd)
  );

  always #5 clk = ~clk;

  // Upstream address generator: holds pix_addr for pix_n words, ROM output one register behind.
  logic [17:0] rom_mem [0:2047];
  int pix_addr = -1;
  int pix_n = 1;
  int addr = 0;
  int hold = 0;

  always @(posedge clk) begin
    if (rst) begin
      addr <= 0;
      hold <= 0;
    end else if (cnt_en) begin
      if (addr == pix_addr && hold < pix_n - 1) hold <= hold + 1;
      else begin
        addr <= addr + 1;
        hold <= 0;
      end
    end
    rom_word <= rom_mem[addr % 2048];
  end

  // Bus monitor
  logic [16:0] wr_log [$];
  int          lo_log [$];
  int lo_run = 0, cnt_seen = 0, cnt_double = 0, cs_bad = 0, cs_break = 0, unstable = 0;
  logic prev_wr = 1'b1, prev_cnt = 1'b0, seen_wr = 1'b0;
  logic [16:0] fall_word = '0;

  always @(negedge clk) begin
    if (rst) begin
      lo_run   = 0;
      prev_wr  = 1'b1;
      prev_cnt = 1'b0;
      seen_wr  = 1'b0;
    end else begin
      if (!lcd.lcd_wr_n) begin
        if (prev_wr) fall_word = {lcd.lcd_dc, lcd.lcd_data};
        else if ({lcd.lcd_dc, lcd.lcd_data} != fall_word) unstable++;
        lo_run++;
        if (lcd.lcd_cs_n) cs_bad++;
      end else if (!prev_wr) begin
        if (!lcd.lcd_cs_n) begin
          wr_log.push_back({lcd.lcd_dc, lcd.lcd_data});
          lo_log.push_back(lo_run);
          seen_wr = 1'b1;
        end
        lo_run = 0;
      end
      if (seen_wr && !done && lcd.lcd_cs_n) cs_break++;
      if (cnt_en) begin
        cnt_seen++;
        if (prev_cnt) cnt_double++;
      end
      prev_wr  = lcd.lcd_wr_n;
      prev_cnt = cnt_en;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: expected writes, cnt_en pulses and start-to-done cycles.
  logic [16:0] exp_wr [$];

  task automatic model(output int exp_t, output int exp_cnt);
    logic [17:0] w;
    int reps;
    exp_t = 0;
    exp_cnt = 0;
    exp_wr.delete();
    for (int a = 0; a < 2048; a++) begin
      w = rom_mem[a];
      if (w[17:16] == C_END) begin
        exp_t += LAT + 1;
        break;
      end
      reps = (a == pix_addr) ? pix_n : 1;
      for (int r = 0; r < reps; r++) begin
        exp_cnt++;
        if (w[17:16] == C_DLY) exp_t += LAT + 1 + int'(w[15:0]) * CPM + 1;
        else begin
          exp_t += LAT + 1 + LO + HI + 1;
          exp_wr.push_back({w[16], w[15:0]});
        end
      end
    end
  endtask

  task automatic gen(input int n_init, input bit writes_only, input int npix);
    logic [1:0]  op;
    logic [15:0] v;
    for (int a = 0; a < n_init; a++) begin
      op = writes_only ? 2'($urandom % 2) : 2'($urandom % 3);
      v  = (op == C_DLY) ? 16'($urandom % 4) : 16'($urandom);
      rom_mem[a] = {op, v};
    end
    if (npix > 0) begin
      rom_mem[n_init]     = {C_DATA, 16'hF800};
      rom_mem[n_init + 1] = {C_END, 16'h0000};
      pix_addr = n_init;
      pix_n    = npix;
    end else begin
      rom_mem[n_init] = {C_END, 16'h0000};
      pix_addr = -1;
      pix_n    = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_outputs",
          {busy, done, cnt_en, lcd.lcd_cs_n, lcd.lcd_wr_n, lcd.lcd_dc, lcd.lcd_data},
          {3'b000, 1'b1, 1'b1, 1'b0, 16'h0000});
    rst = 1'b0;
    wr_log.delete();
    lo_log.delete();
    cnt_seen = 0; cnt_double = 0; cs_bad = 0; cs_break = 0; unstable = 0;
  endtask

  task automatic run(input string name, input bit stray_start);
    int exp_t, exp_cnt, cyc, n_wr, n_cnt;
    logic [16:0] got;
    model(exp_t, exp_cnt);
    do_reset();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!done && cyc < exp_t + 100) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (stray_start && !done) ? ($urandom % 7 == 0) : 1'b0;
    end
    start = 1'b0;
    check({name, "_cycles"}, cyc, exp_t);
    check({name, "_done"}, {busy, done, lcd.lcd_cs_n}, 3'b011);
    @(negedge clk);
    check({name, "_cnt_en"}, cnt_seen, exp_cnt);
    check({name, "_nwrites"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : '1;
      check({name, "_word"}, got, exp_wr[i]);
      check({name, "_lo_width"}, (i < lo_log.size()) ? lo_log[i] : -1, LO);
    end
    check({name, "_protocol"}, {cnt_double, cs_bad, cs_break, unstable}, 0);
    n_wr  = wr_log.size();
    n_cnt = cnt_seen;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 start = (k % 3 == 0);
    end
    start = 1'b0;
    @(negedge clk);
    check({name, "_hold_done"}, {busy, done}, 2'b01);
    check({name, "_hold_counts"}, {cnt_seen[15:0], 16'(wr_log.size())}, {n_cnt[15:0], 16'(n_wr)});
  endtask

  task automatic mid_write_reset();
    int lows, cyc;
    logic prev;
    do_reset();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lows = 0; cyc = 0; prev = 1'b1;
    while (lows < 5 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (!lcd.lcd_wr_n && prev) lows++;
      prev = lcd.lcd_wr_n;
    end
    check("mid_reached_5th", lows, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_outputs",
          {lcd.lcd_wr_n, lcd.lcd_cs_n, busy, done, cnt_en, lcd.lcd_dc, lcd.lcd_data},
          {1'b1, 1'b1, 3'b000, 1'b0, 16'h0000});
    @(negedge clk);
    check("mid_rst_writes", wr_log.size(), 4);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom_mem[a] = {C_END, 16'h0000};

    rom_mem[0] = {C_CMD, 16'h0011};
    rom_mem[1] = {C_END, 16'h0000};
    pix_addr = -1; pix_n = 1;
    run("cmd11", 1'b0);

    rom_mem[0] = {C_DLY, 16'd3};
    run("delay3", 1'b0);

    rom_mem[0] = {C_DLY, 16'd0};
    run("delay0", 1'b0);

    for (int r = 0; r < 6; r++) begin
      gen(3 + int'($urandom % 10), 1'b0, int'($urandom % 41));
      run("rand", 1'b1);
    end

    gen(106, 1'b0, int'(PIXEL_COUNT / 64));
    run("chain", 1'b1);

    gen(12, 1'b1, 3);
    mid_write_reset();
    run("replay", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
